riscv_utype: RTL and testbench
==============================

Name: riscv_utype

Overview:
- Registered RISC-V U-type field extractor and evaluator for the decode stage.
- Splits a 32-bit instruction into its imm[31:12], rd and opcode fields, and flags LUI and AUIPC.
- Forms the 32-bit U-immediate and the architectural result: the immediate for LUI, pc + immediate for AUIPC.
- Sits between instruction fetch and register-file writeback; one-cycle latency behind a valid strobe.

Parameters:
- XLEN, 32, datapath width of pc, imm32 and result. Only 32 is supported.
- OPC_LUI, 7'h37, opcode that identifies LUI.
- OPC_AUIPC, 7'h17, opcode that identifies AUIPC.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  inst and pc are valid this cycle
- inst  in  32  instruction word
- pc  in  32  address of inst
- out_valid  out  1  registered outputs are valid
- imm  out  20  inst[31:12]
- rd  out  5  inst[11:7]
- opcode  out  7  inst[6:0]
- imm32  out  32  {inst[31:12], 12'h000}
- is_lui  out  1  opcode == OPC_LUI
- is_auipc  out  1  opcode == OPC_AUIPC
- is_utype  out  1  is_lui | is_auipc
- result  out  32  value for rd: imm32 for LUI, pc + imm32 for AUIPC, 0 otherwise
- rd_we  out  1  is_utype & (rd != 0)

Behaviour:
- Reset: while rst_n is low, every output is 0 asynchronously, including out_valid.
- Capture:
  - On each rising clk with in_valid=1, all outputs register from the current inst and pc.
  - out_valid is 1 in the following cycle. Latency is exactly 1 cycle; throughput is 1 instruction per cycle.
- Hold: with in_valid=0, out_valid drops to 0 on the next edge. The data outputs hold their last values and are not cleared.
- Field extraction is unconditional:
  - imm, rd and opcode reflect the raw bit slices for any opcode, including non-U-type words, all-zero and all-one words.
- Type flags:
  - Exact 7-bit compare against the opcode parameters.
  - Any other opcode gives is_lui = is_auipc = is_utype = 0, result = 0 and rd_we = 0.
- Arithmetic:
  - The pc + imm32 addition is modulo 2^32; the carry-out is discarded, so wrap-around is silent.
  - imm32 low 12 bits are always 0. No sign extension is needed at XLEN=32.
- rd = x0: is_utype and result are still computed, but rd_we = 0.
- Reset mid-stream: asserting rst_n low clears out_valid immediately. The first capture after release happens on the first edge with in_valid=1.
- No backpressure: downstream must accept out_valid whenever it is asserted.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OPC_LUI, OPC_AUIPC and any other base opcodes;
  - field bit positions (RD_LSB=7, RD_MSB=11, IMM_U_LSB=12);
  - XLEN.
- Optional sub-module riscv_utype_eval (combinational):
  - inputs: inst, pc;
  - outputs: the flags, imm32 and result.
  - The top level holds only the output register stage.

Test Plan:
- inst=32'h12345678, in_valid=1 -> next cycle:
  - imm=20'h12345, rd=12, opcode=7'h78, imm32=32'h12345000;
  - is_utype=0, result=0, rd_we=0, out_valid=1.
- inst=32'habcdef12 -> imm=20'habcde, rd=30, opcode=7'h12, is_utype=0.
- inst=32'h00000000 -> imm=0, rd=0, opcode=0, all flags 0.
- inst=32'hffffffff -> imm=20'hfffff, rd=31, opcode=7'h7f, is_utype=0.
- LUI and AUIPC, both with imm=20'h12345 and rd=x5:
  - LUI inst=32'h123452b7 -> is_lui=1, result=32'h12345000, rd_we=1.
  - AUIPC inst=32'h12345297 with pc=32'h00001000 -> is_auipc=1, result=32'h12346000.
- AUIPC wrap and rd=x0:
  - inst=32'hfffff017, pc=32'h00002000 -> result=32'h00001000, rd=0, rd_we=0.
  - Then assert rst_n low mid-stream -> all outputs 0 immediately, out_valid=0 until the next in_valid capture.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: base opcodes, field positions and U-type helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam int unsigned OPC_MSB   = 6;
  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned RD_MSB    = 11;
  localparam int unsigned IMM_U_LSB = 12;

  // Evaluated U-type view of one instruction, registered as a unit by the top.
  typedef struct packed {
    logic            is_lui;
    logic            is_auipc;
    logic            is_utype;
    logic            rd_we;
    logic [XLEN-1:0] imm32;
    logic [XLEN-1:0] result;
  } utype_eval_t;

  function automatic logic [31:0] utype_imm32(input logic [31:0] inst);
    return {inst[31:IMM_U_LSB], {IMM_U_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/riscv_utype_eval.sv
// Combinational U-type evaluator: type flags, U-immediate and architectural result.
module riscv_utype_eval
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN_P    = XLEN,
  parameter logic [6:0]  OPC_LUI_P = OPC_LUI,
  parameter logic [6:0]  OPC_AUI_P = OPC_AUIPC
) (
  input  logic [31:0]       inst,
  input  logic [XLEN_P-1:0] pc,
  output logic              is_lui,
  output logic              is_auipc,
  output logic              is_utype,
  output logic              rd_we,
  output logic [XLEN_P-1:0] imm32,
  output logic [XLEN_P-1:0] result
);

  logic [6:0] w_opcode;
  logic [4:0] w_rd;

  assign w_opcode = inst[OPC_MSB:0];
  assign w_rd     = inst[RD_MSB:RD_LSB];

  always_comb begin
    imm32    = utype_imm32(inst);
    is_lui   = (w_opcode == OPC_LUI_P);
    is_auipc = (w_opcode == OPC_AUI_P);
    is_utype = is_lui | is_auipc;
    rd_we    = is_utype & (w_rd != 5'd0);
    result   = '0;
    // Carry-out of the AUIPC add is dropped: pc-relative wrap is architectural.
    if (is_lui) begin
      result = imm32;
    end else if (is_auipc) begin
      result = pc + imm32;
    end
  end

endmodule

// File: rtl/riscv_utype.sv
// Registered U-type field extractor: one-cycle capture stage behind in_valid.
module riscv_utype
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = riscv_pkg::XLEN,
  parameter logic [6:0]  OPC_LUI   = riscv_pkg::OPC_LUI,
  parameter logic [6:0]  OPC_AUIPC = riscv_pkg::OPC_AUIPC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic [19:0]     imm,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] imm32,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            is_utype,
  output logic [XLEN-1:0] result,
  output logic            rd_we
);

  utype_eval_t w_eval;
  utype_eval_t r_eval;
  logic        r_valid;
  logic [19:0] r_imm;
  logic [4:0]  r_rd;
  logic [6:0]  r_opcode;

  riscv_utype_eval #(
    .XLEN_P    (XLEN),
    .OPC_LUI_P (OPC_LUI),
    .OPC_AUI_P (OPC_AUIPC)
  ) u_eval (
    .inst     (inst),
    .pc       (pc),
    .is_lui   (w_eval.is_lui),
    .is_auipc (w_eval.is_auipc),
    .is_utype (w_eval.is_utype),
    .rd_we    (w_eval.rd_we),
    .imm32    (w_eval.imm32),
    .result   (w_eval.result)
  );

  // Data registers only load on in_valid; they hold while the stream idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_imm    <= '0;
      r_rd     <= '0;
      r_opcode <= '0;
      r_eval   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_imm    <= inst[31:IMM_U_LSB];
        r_rd     <= inst[RD_MSB:RD_LSB];
        r_opcode <= inst[OPC_MSB:0];
        r_eval   <= w_eval;
      end
    end
  end

  assign out_valid = r_valid;
  assign imm       = r_imm;
  assign rd        = r_rd;
  assign opcode    = r_opcode;
  assign imm32     = r_eval.imm32;
  assign is_lui    = r_eval.is_lui;
  assign is_auipc  = r_eval.is_auipc;
  assign is_utype  = r_eval.is_utype;
  assign result    = r_eval.result;
  assign rd_we     = r_eval.rd_we;

endmodule

// File: tb/tb_riscv_utype.sv
// Directed vector bench for riscv_utype: table of hand-computed vectors plus hold/reset sequences.
module tb_riscv_utype;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_valid;
  logic [19:0] imm;
  logic [4:0]  rd;
  logic [6:0]  opcode;
  logic [31:0] imm32;
  logic        is_lui;
  logic        is_auipc;
  logic        is_utype;
  logic [31:0] result;
  logic        rd_we;

  int vectors;
  int miscompares;

  riscv_utype dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inst      (inst),
    .pc        (pc),
    .out_valid (out_valid),
    .imm       (imm),
    .rd        (rd),
    .opcode    (opcode),
    .imm32     (imm32),
    .is_lui    (is_lui),
    .is_auipc  (is_auipc),
    .is_utype  (is_utype),
    .result    (result),
    .rd_we     (rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [31:0] imm32;
    logic        is_lui;
    logic        is_auipc;
    logic [31:0] result;
    logic        rd_we;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_valid, input vec_t v);
    vectors++;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    chk({tag, ".imm"},       {12'd0, imm},       {12'd0, v.imm});
    chk({tag, ".rd"},        {27'd0, rd},        {27'd0, v.rd});
    chk({tag, ".opcode"},    {25'd0, opcode},    {25'd0, v.opcode});
    chk({tag, ".imm32"},     imm32,              v.imm32);
    chk({tag, ".is_lui"},    {31'd0, is_lui},    {31'd0, v.is_lui});
    chk({tag, ".is_auipc"},  {31'd0, is_auipc},  {31'd0, v.is_auipc});
    chk({tag, ".is_utype"},  {31'd0, is_utype},  {31'd0, v.is_lui | v.is_auipc});
    chk({tag, ".result"},    result,             v.result);
    chk({tag, ".rd_we"},     {31'd0, rd_we},     {31'd0, v.rd_we});
  endtask

  vec_t zero_v;
  vec_t last_v;

  initial begin
    //            inst          pc            imm       rd  op     imm32         lui  aui  result        we
    tbl[0] = '{32'h12345678, 32'h0000_0000, 20'h12345, 12, 7'h78, 32'h12345000, 0, 0, 32'h0,        0};
    tbl[1] = '{32'habcdef12, 32'h0000_0040, 20'habcde, 30, 7'h12, 32'habcde000, 0, 0, 32'h0,        0};
    tbl[2] = '{32'h00000000, 32'h0000_0000, 20'h00000, 0,  7'h00, 32'h00000000, 0, 0, 32'h0,        0};
    tbl[3] = '{32'hffffffff, 32'hffff_fff0, 20'hfffff, 31, 7'h7f, 32'hfffff000, 0, 0, 32'h0,        0};
    tbl[4] = '{32'h123452b7, 32'h0000_1000, 20'h12345, 5,  7'h37, 32'h12345000, 1, 0, 32'h12345000, 1};
    tbl[5] = '{32'h12345297, 32'h0000_1000, 20'h12345, 5,  7'h17, 32'h12345000, 0, 1, 32'h12346000, 1};
    tbl[6] = '{32'hfffff017, 32'h0000_2000, 20'hfffff, 0,  7'h17, 32'hfffff000, 0, 1, 32'h00001000, 0};
    tbl[7] = '{32'habcde037, 32'h0000_0000, 20'habcde, 0,  7'h37, 32'habcde000, 1, 0, 32'habcde000, 0};
    tbl[8] = '{32'h00001097, 32'hffff_f000, 20'h00001, 1,  7'h17, 32'h00001000, 0, 1, 32'h00000000, 1};
    tbl[9] = '{32'h123452b6, 32'h0000_1000, 20'h12345, 5,  7'h36, 32'h12345000, 0, 0, 32'h0,        0};
    zero_v = '{32'h0, 32'h0, 20'h0, 0, 7'h0, 32'h0, 0, 0, 32'h0, 0};

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    inst = 32'h0;
    pc = 32'h0;
    #12;
    chk_all("reset", 1'b0, zero_v);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back captures: in_valid held high across the whole table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      inst = tbl[i].inst;
      pc = tbl[i].pc;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), 1'b1, tbl[i]);
    end

    // Idle: out_valid drops, data holds even though inputs change.
    last_v = tbl[9];
    @(negedge clk);
    in_valid = 1'b0;
    inst = tbl[4].inst;
    pc = 32'hdead_beef;
    @(posedge clk);
    #1;
    chk_all("hold1", 1'b0, last_v);
    @(posedge clk);
    #1;
    chk_all("hold2", 1'b0, last_v);

    // Capture AUIPC wrap, then reset asynchronously mid-cycle.
    @(negedge clk);
    in_valid = 1'b1;
    inst = tbl[6].inst;
    pc = tbl[6].pc;
    @(posedge clk);
    #1;
    chk_all("wrap", 1'b1, tbl[6]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst_idle", 1'b0, zero_v);
    @(negedge clk);
    in_valid = 1'b1;
    inst = tbl[5].inst;
    pc = tbl[5].pc;
    @(posedge clk);
    #1;
    chk_all("first_capture", 1'b1, tbl[5]);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("drop_valid", 1'b0, tbl[5]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
